// File: rtl/clk_monitor.sv
// clk_monitor: measures rise-to-rise period of an asynchronous divided clock in clk cycles.
// Optional stall detection is compiled in when CLK_MONITOR_TIMEOUT_EN is defined;
// without it the STALL state is unreachable and stalled is tied low.
module clk_monitor #(
  parameter int MAX_COUNT      = 50000000,
  parameter int NUMBER_OF_BITS = $clog2(MAX_COUNT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_clk,
  input  logic                      clr,
  output logic                      rise_stb,
  output logic                      fall_stb,
  output logic [NUMBER_OF_BITS-1:0] period,
  output logic                      period_vld,
  output logic                      stalled
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] STALL   = 2'd2;

  localparam logic [NUMBER_OF_BITS-1:0] CNT_MAX = NUMBER_OF_BITS'(MAX_COUNT);
  localparam logic [NUMBER_OF_BITS-1:0] CNT_ONE = NUMBER_OF_BITS'(1);

  logic                      sync1_q, sync2_q, hist_q;
  logic [2:0]                arm_q;
  logic                      rise_p_q, fall_p_q;
  logic                      rise_q, fall_q;
  logic [1:0]                state_q, state_d;
  logic [NUMBER_OF_BITS-1:0] cnt_q, cnt_d;
  logic [NUMBER_OF_BITS-1:0] period_q, period_d;
  logic                      vld_q, vld_d;
  logic                      edge_w;
  logic [NUMBER_OF_BITS-1:0] cnt_inc;

  assign edge_w  = sync2_q ^ hist_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Synchronizer, history flop and strobe pipeline; arm_q blocks the spurious
  // edge seen while the history flop still holds its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= 1'b0;
      arm_q    <= 3'b000;
      rise_p_q <= 1'b0;
      fall_p_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= in_clk;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      arm_q    <= {arm_q[1:0], 1'b1};
      rise_p_q <= arm_q[2] & edge_w & sync2_q;
      fall_p_q <= arm_q[2] & edge_w & ~sync2_q;
      rise_q   <= rise_p_q;
      fall_q   <= fall_p_q;
    end
  end

`ifdef CLK_MONITOR_TIMEOUT_EN
  logic stalled_q, stalled_d;
`endif

  // Measurement FSM: counts cycles between staged rises; clr overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    vld_d    = 1'b0;
`ifdef CLK_MONITOR_TIMEOUT_EN
    stalled_d = 1'b0;
`endif
    if (clr) begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_p_q) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise_p_q) begin
            period_d = cnt_q;
            vld_d    = 1'b1;
            cnt_d    = CNT_ONE;
          end
`ifdef CLK_MONITOR_TIMEOUT_EN
          else if (cnt_q == CNT_MAX) state_d = STALL;
`endif
          else cnt_d = cnt_inc;
        end
`ifdef CLK_MONITOR_TIMEOUT_EN
        STALL: begin
          if (rise_p_q) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
          end else stalled_d = 1'b1;
        end
`else
        STALL: state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and measurement registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
    end
  end

`ifdef CLK_MONITOR_TIMEOUT_EN
  // Stall level is registered one cycle after entering STALL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stalled_q <= 1'b0;
    else stalled_q <= stalled_d;
  end
  assign stalled = stalled_q;
`else
  assign stalled = 1'b0;
`endif

  assign rise_stb   = rise_q;
  assign fall_stb   = fall_q;
  assign period     = period_q;
  assign period_vld = vld_q;

endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: table-driven, directed and randomized checks of clk_monitor against an event-level model.
module tb_clk_monitor;
  localparam int MAXC = 100;
  localparam int NB   = $clog2(MAXC + 1);
`ifdef CLK_MONITOR_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, in_clk = 1'b0, clr = 1'b0;
  logic rise_stb, fall_stb, period_vld, stalled;
  logic [NB-1:0] period;
  int checks = 0, failures = 0;

  clk_monitor #(.MAX_COUNT(MAXC), .NUMBER_OF_BITS(NB)) dut (
    .clk(clk), .rst(rst), .in_clk(in_clk), .clr(clr),
    .rise_stb(rise_stb), .fall_stb(fall_stb), .period(period),
    .period_vld(period_vld), .stalled(stalled)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: edges are events in sampled-cycle time, strobes appear 3 cycles later,
  // period is the distance between consecutive rise strobes capped at MAXC.
  int cyc = 0, last = -1, ep = 0;
  bit pd = 0, pv = 0, er = 0, ef = 0, ev = 0, es = 0;
  bit rq[$], fq[$];

  task automatic model_reset();
    pv = 0; pd = 0; last = -1;
    rq = '{1'b0, 1'b0, 1'b0};
    fq = '{1'b0, 1'b0, 1'b0};
    er = 0; ef = 0; ev = 0; es = 0; ep = 0;
  endtask

  task automatic model_edge();
    bit r, f;
    cyc++;
    if (!rst) model_reset();
    else begin
      r = pv && in_clk && !pd;
      f = pv && !in_clk && pd;
      pd = in_clk; pv = 1;
      rq.push_back(r); fq.push_back(f);
      er = rq.pop_front(); ef = fq.pop_front();
      if (clr) begin
        last = -1; ep = 0; ev = 0; es = 0;
      end else if (er) begin
        ev = (last >= 0) && (!TO || (cyc - last) <= MAXC);
        if (ev) ep = ((cyc - last) > MAXC) ? MAXC : cyc - last;
        last = cyc; es = 0;
      end else begin
        ev = 0;
        es = TO && (last >= 0) && (cyc - last) > MAXC;
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, a, e);
    end
  endtask

  int n_rise, n_vld, n_fall, last_per, first_vld, last_rise_cyc, stall_cyc, fall_gap;

  task automatic clear_cap();
    n_rise = 0; n_vld = 0; n_fall = 0; last_per = -1; first_vld = -1;
    last_rise_cyc = -1; stall_cyc = -1; fall_gap = -1;
  endtask

  task automatic step(input logic ic, input logic cl);
    logic [NB+3:0] exp_v;
    in_clk = ic; clr = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_v = {er, ef, ev, es, NB'(ep)};
    chk("outputs{rise,fall,vld,stalled,period}", 32'({rise_stb, fall_stb, period_vld, stalled, period}), 32'(exp_v));
    if (rise_stb) begin n_rise++; if (n_rise == 1) first_vld = int'(period_vld); last_rise_cyc = cyc; end
    if (period_vld) begin n_vld++; last_per = int'(period); end
    if (fall_stb) begin n_fall++; fall_gap = cyc - last_rise_cyc; end
    if (stalled && stall_cyc < 0) stall_cyc = cyc;
  endtask

  task automatic wave(input int h, input int n);
    repeat (n) begin
      repeat (h) step(1, 0);
      repeat (h) step(0, 0);
    end
  endtask

  typedef struct { int half; int exp_per; } vec_t;
  vec_t tbl[7];

  initial begin
    tbl = '{'{10, 20}, '{1, 2}, '{2, 4}, '{3, 6}, '{7, 14}, '{25, 50}, '{50, 100}};
    model_reset();
    clear_cap();
    repeat (3) step(0, 0);
    chk("reset_outputs", 32'({rise_stb, fall_stb, period_vld, stalled, period}), 32'h0);
    rst = 1'b1;
    repeat (4) step(0, 0);

    // Square waves of several half-periods with known periods.
    for (int i = 0; i < 7; i++) begin
      step(0, 1);
      clear_cap();
      wave(tbl[i].half, 3);
      repeat (6) step(0, 0);
      chk("tbl_first_rise_vld", first_vld, 0);
      chk("tbl_n_vld", n_vld, 2);
      chk("tbl_period", last_per, tbl[i].exp_per);
      chk("tbl_fall_gap", fall_gap, tbl[i].half);
    end

    // Reset mid-measurement discards the partial count.
    step(0, 1);
    wave(10, 2);
    repeat (5) step(1, 0);
    rst = 1'b0;
    repeat (5) begin
      step(1, 0);
      chk("rst_mid_outputs", 32'({rise_stb, fall_stb, period_vld, stalled, period}), 32'h0);
    end
    rst = 1'b1;
    clear_cap();
    repeat (5) step(1, 0);
    repeat (10) step(0, 0);
    wave(10, 2);
    chk("rst_n_rise", n_rise, 2);
    chk("rst_first_vld", first_vld, 0);
    chk("rst_n_vld", n_vld, 1);
    chk("rst_period", last_per, 20);

    // in_clk held low 150 cycles after a rise: stall or saturated period.
    step(0, 1);
    clear_cap();
    repeat (10) step(1, 0);
    repeat (150) step(0, 0);
    chk("stall_delay", TO ? stall_cyc - last_rise_cyc : stall_cyc, TO ? 101 : -1);
    clear_cap();
    repeat (10) step(1, 0);
    chk("stall_release_n_vld", n_vld, TO ? 0 : 1);
    if (!TO) chk("sat_period", last_per, MAXC);
    chk("stall_release_stalled", 32'(stalled), 0);
    repeat (10) step(0, 0);
    wave(10, 1);
    chk("after_stall_period", last_per, 20);
    chk("after_stall_n_vld", n_vld, TO ? 1 : 2);

    // clr coincident with the rise strobe.
    step(0, 1);
    wave(10, 2);
    repeat (3) step(1, 0);
    step(1, 1);
    chk("clr_rise_stb", 32'(rise_stb), 1);
    chk("clr_vld", 32'(period_vld), 0);
    chk("clr_period", 32'(period), 0);
    clear_cap();
    repeat (6) step(1, 0);
    repeat (10) step(0, 0);
    wave(10, 2);
    chk("clr_next_first_vld", first_vld, 0);
    chk("clr_next_n_vld", n_vld, 1);
    chk("clr_next_period", last_per, 20);

    // in_clk high at reset release, then falling.
    rst = 1'b0;
    repeat (3) step(1, 0);
    rst = 1'b1;
    clear_cap();
    repeat (7) step(1, 0);
    repeat (3) step(0, 0);
    chk("hi_release_fall_early", 32'(fall_stb), 0);
    step(0, 0);
    chk("hi_release_fall_stb", 32'(fall_stb), 1);
    repeat (5) step(0, 0);
    chk("hi_release_n_rise", n_rise, 0);
    chk("hi_release_n_fall", n_fall, 1);

    // Randomized segments against the model.
    repeat (60) begin
      int op;
      op = $urandom_range(0, 19);
      if (op == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 4)) step(1'($urandom_range(0, 1)), 0);
        rst = 1'b1;
      end else begin
        int len;
        len = (op == 1) ? $urandom_range(95, 130) : $urandom_range(1, 30);
        repeat (len) step(~in_clk == 1'b1 ? 1'b1 : 1'b0, 1'($urandom_range(0, 149) == 0));
      end
    end
    repeat (10) step(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
